// File: rtl/wb_bram_slave_pkg.sv
// Shared definitions for the Wishbone block-RAM slave: FSM encoding,
// counter width and the byte-lane helper.
package wb_bram_slave_pkg;

  localparam int COUNT_W = 16;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ACCESS = 3'd2;
  localparam logic [STATE_W-1:0] ST_RESP   = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERR    = 3'd4;

  // Number of byte-select lines for a data bus of dw bits.
  function automatic int wb_sel_w(input int dw);
    return dw / 8;
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_bram_core.sv
// Synchronous single-port RAM with byte-lane writes and a registered read.
// Storage only: no reset, no protocol logic.
module wb_bram_core
  import wb_bram_slave_pkg::*;
#(
  parameter int    DW        = 32,
  parameter int    DEPTH     = 512,
  parameter string INIT_FILE = "NONE"
) (
  input  logic                     sys_clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [wb_sel_w(DW)-1:0]  sel,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  localparam int SEL_W = wb_sel_w(DW);

  logic [DW-1:0] mem [DEPTH];

  // Power-up contents are all zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // One enabled edge performs the byte-masked write and captures the read word.
  // NOTE: the array is deliberately never reset; a reset loop over every word
  // would stop it mapping onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (en) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (we && sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_bram_slave.sv
// Wishbone classic slave in front of wb_bram_core: address decode,
// access FSM with optional wait states, and saturating access counters.
module wb_bram_slave
  import wb_bram_slave_pkg::*;
#(
  parameter int              DW          = 32,
  parameter int              AW          = 32,
  parameter int              MEM_DEPTH   = 512,
  parameter logic [AW-1:0]   BASE_ADDR   = '0,
  parameter int              WAIT_CYCLES = 0,
  parameter string           INIT_FILE   = "NONE"
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic [AW-1:0]           wbs_adr_i,
  input  logic                    wbs_we_i,
  input  logic [DW-1:0]           wbs_dat_i,
  input  logic [wb_sel_w(DW)-1:0] wbs_sel_i,
  output logic [DW-1:0]           wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [COUNT_W-1:0]      rd_cnt_o,
  output logic [COUNT_W-1:0]      wr_cnt_o
);

  localparam int            SEL_W      = wb_sel_w(DW);
  localparam int            BYTE_SHIFT = $clog2(SEL_W);
  localparam int            IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] SPAN       = AW'(MEM_DEPTH * SEL_W);
  localparam logic [3:0]    WAIT_LOAD  = 4'(WAIT_CYCLES);

  logic [STATE_W-1:0] state;
  logic [3:0]         wait_cnt;
  logic [IDX_W-1:0]   idx_q;
  logic               we_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DW-1:0]      wdat_q;
  logic [DW-1:0]      ram_rdata;
  logic [AW-1:0]      off;
  logic               hit;
  logic               req;

  assign req = wbs_cyc_i & wbs_stb_i;
  assign off = wbs_adr_i - BASE_ADDR;
  // Comparing the byte offset against the window size is the same test as
  // word index < MEM_DEPTH, with the ignored low bits folded in.
  assign hit = (wbs_adr_i >= BASE_ADDR) && (off < SPAN);

  // Capture the request when it is accepted; these feed the RAM only.
  always_ff @(posedge sys_clk) begin
    if (state == ST_IDLE && req) begin
      idx_q  <= off[BYTE_SHIFT +: IDX_W];
      we_q   <= wbs_we_i;
      sel_q  <= wbs_sel_i;
      wdat_q <= wbs_dat_i;
    end
  end

  // Access sequencing, one-cycle response pulses and access counters.
  // NOTE: all state here uses <= so every branch sees the pre-edge values;
  // the pulse outputs default low each cycle and are raised only when due.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            wait_cnt <= WAIT_LOAD;
            if (!hit)                 state <= ST_ERR;
            else if (WAIT_CYCLES > 0) state <= ST_WAIT;
            else                      state <= ST_ACCESS;
          end
        end
        ST_WAIT: begin
          // Master abandoning the cycle here leaves the RAM untouched.
          if (!wbs_cyc_i)             state    <= ST_IDLE;
          else if (wait_cnt == 4'd1)  state    <= ST_ACCESS;
          else                        wait_cnt <= wait_cnt - 4'd1;
        end
        ST_ACCESS: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (wbs_cyc_i) begin
            wbs_ack_o <= 1'b1;
            if (we_q) begin
              wr_cnt_o <= sat_inc(wr_cnt_o);
            end else begin
              rd_cnt_o  <= sat_inc(rd_cnt_o);
              wbs_dat_o <= ram_rdata;
            end
          end
        end
        ST_ERR: begin
          wbs_err_o <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wb_bram_core #(
    .DW        (DW),
    .DEPTH     (MEM_DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .sys_clk (sys_clk),
    .en      (state == ST_ACCESS),
    .we      (we_q),
    .sel     (sel_q),
    .addr    (idx_q),
    .wdata   (wdat_q),
    .rdata   (ram_rdata)
  );

endmodule

// File: tb/tb_wb_bram_slave.sv
// Scoreboard bench for wb_bram_slave. Three instances cover the
// zero-wait, 3-wait (offset base) and 4-wait configurations.
module tb_wb_bram_slave;

  localparam int N    = 3;
  localparam int SPAN = 512 * 4;

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [N];
  logic        cyc    [N];
  logic        stb    [N];
  logic        we     [N];
  logic [31:0] adr    [N];
  logic [31:0] dat_i  [N];
  logic [3:0]  sel    [N];
  logic [31:0] dat_o  [N];
  logic        ack    [N];
  logic        err    [N];
  logic [15:0] rd_cnt [N];
  logic [15:0] wr_cnt [N];

  wb_bram_slave #(.DW(32), .AW(32), .MEM_DEPTH(512), .BASE_ADDR(32'h0),
                  .WAIT_CYCLES(0), .INIT_FILE("NONE")) dut_a (
    .sys_clk(clk), .reset(rst[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_adr_i(adr[0]), .wbs_we_i(we[0]), .wbs_dat_i(dat_i[0]), .wbs_sel_i(sel[0]),
    .wbs_dat_o(dat_o[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]),
    .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0]));

  wb_bram_slave #(.DW(32), .AW(32), .MEM_DEPTH(512), .BASE_ADDR(32'h1000),
                  .WAIT_CYCLES(3), .INIT_FILE("NONE")) dut_b (
    .sys_clk(clk), .reset(rst[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_adr_i(adr[1]), .wbs_we_i(we[1]), .wbs_dat_i(dat_i[1]), .wbs_sel_i(sel[1]),
    .wbs_dat_o(dat_o[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]),
    .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]));

  wb_bram_slave #(.DW(32), .AW(32), .MEM_DEPTH(512), .BASE_ADDR(32'h0),
                  .WAIT_CYCLES(4), .INIT_FILE("NONE")) dut_c (
    .sys_clk(clk), .reset(rst[2]), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]),
    .wbs_adr_i(adr[2]), .wbs_we_i(we[2]), .wbs_dat_i(dat_i[2]), .wbs_sel_i(sel[2]),
    .wbs_dat_o(dat_o[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2]),
    .rd_cnt_o(rd_cnt[2]), .wr_cnt_o(wr_cnt[2]));

  // ---------------- bookkeeping ----------------
  int          n_pass  = 0;
  int          n_total = 0;
  int unsigned cycle   = 0;
  exp_t        sb [N][$];
  bit [31:0]   mem_model [int];
  int          rd_exp [N];
  int          wr_exp [N];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int d,
                       input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)",
                  name, d, act, expv, cycle);
  endtask

  // ---------------- reference model ----------------
  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 4;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? 32'h1000 : 32'h0;
  endfunction

  function automatic bit in_range(input int d, input logic [31:0] a);
    return (a >= base_of(d)) && ((a - base_of(d)) < SPAN);
  endfunction

  // Applies one access to the model; returns the response the bus should see.
  function automatic exp_t model_access(input int d, input logic [31:0] a, input logic w,
                                        input logic [31:0] data, input logic [3:0] s,
                                        input int unsigned issue, input bit counted);
    exp_t      e;
    int        key;
    bit [31:0] word;
    if (!in_range(d, a)) begin
      e.is_err = 1'b1;
      e.dat    = '0;
      e.at     = issue + 1;
      return e;
    end
    key      = d * 4096 + int'((a - base_of(d)) / 4);
    word     = mem_model.exists(key) ? mem_model[key] : 32'h0;
    e.is_err = 1'b0;
    e.at     = issue + 2 + wait_of(d);
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = data[8*b +: 8];
      mem_model[key] = word;
      e.dat = '0;
      if (counted && wr_exp[d] < 65535) wr_exp[d]++;
    end else begin
      e.dat = word;
      if (counted && rd_exp[d] < 65535) rd_exp[d]++;
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < N; d++) begin
      if (ack[d] || err[d]) begin
        check("ack_err_exclusive", d, 64'(ack[d] & err[d]), 64'd0);
        if (sb[d].size() == 0) begin
          check("unexpected_resp", d, 64'(ack[d]), 64'(err[d] & 1'b0) | 64'd2);
        end else begin
          e = sb[d].pop_front();
          check("resp_kind",    d, 64'(err[d]), 64'(e.is_err));
          check("resp_dat",     d, 64'(dat_o[d]), 64'(e.dat));
          check("resp_latency", d, 64'(cycle), 64'(e.at));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_resp(input int d);
    int n = 0;
    while (!(ack[d] || err[d]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_timeout", d, 64'(n < 40), 64'd1);
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] data, input logic [3:0] s);
    @(negedge clk);
    sb[d].push_back(model_access(d, a, w, data, s, cycle + 1, 1'b1));
    cyc[d] = 1'b1; stb[d] = 1'b1; adr[d] = a; we[d] = w; dat_i[d] = data; sel[d] = s;
    @(negedge clk);
    stb[d] = 1'b0;
    wait_resp(d);
    cyc[d] = 1'b0;
  endtask

  task automatic check_cnt(input int d);
    check("rd_cnt", d, 64'(rd_cnt[d]), 64'(rd_exp[d]));
    check("wr_cnt", d, 64'(wr_cnt[d]), 64'(wr_exp[d]));
  endtask

  task automatic check_idle_outputs(input int d);
    check("idle_ack", d, 64'(ack[d]), 64'd0);
    check("idle_err", d, 64'(err[d]), 64'd0);
    check("idle_dat", d, 64'(dat_o[d]), 64'd0);
    check_cnt(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int unsigned issue;
    logic [31:0] a;
    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; dat_i[d] = '0; sel[d] = '0; rd_exp[d] = 0; wr_exp[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) check_idle_outputs(d);

    // Basic write then read-back, zero wait states.
    xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    xfer(0, 32'h10, 1'b0, 32'h0, 4'hF);
    check_cnt(0);

    // Byte-lane merge and an all-lanes-off write.
    xfer(0, 32'h20, 1'b1, 32'h11223344, 4'hF);
    xfer(0, 32'h20, 1'b1, 32'hAABBCCDD, 4'b0101);
    xfer(0, 32'h20, 1'b0, 32'h0, 4'hF);
    xfer(0, 32'h22, 1'b1, 32'hFFFFFFFF, 4'h0);
    xfer(0, 32'h23, 1'b0, 32'h0, 4'h0);
    check_cnt(0);

    // Three wait states with strobe held: second access follows 3+3 cycles later.
    xfer(1, 32'h1000, 1'b1, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    issue = cycle + 1;
    sb[1].push_back(model_access(1, 32'h1000, 1'b0, 32'h0, 4'hF, issue, 1'b1));
    sb[1].push_back(model_access(1, 32'h1000, 1'b0, 32'h0, 4'hF, issue + 6, 1'b1));
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h1000; we[1] = 1'b0; sel[1] = 4'hF;
    wait_resp(1);
    @(negedge clk);
    stb[1] = 1'b0;
    wait_resp(1);
    cyc[1] = 1'b0;
    check_cnt(1);

    // Out-of-range accesses: error in one edge, no RAM or counter effect.
    xfer(0, 32'h0, 1'b1, 32'h76543210, 4'hF);
    xfer(0, 32'h800, 1'b0, 32'h0, 4'hF);
    xfer(0, 32'h800, 1'b1, 32'hFFFF0000, 4'hF);
    xfer(0, 32'h0, 1'b0, 32'h0, 4'hF);
    check_cnt(0);

    // Cycle dropped while the write is already in ACCESS: commits, no ack, not counted.
    @(negedge clk);
    void'(model_access(0, 32'h40, 1'b1, 32'hCAFEF00D, 4'hF, cycle + 1, 1'b0));
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h40; we[0] = 1'b1;
    dat_i[0] = 32'hCAFEF00D; sel[0] = 4'hF;
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (6) @(negedge clk);
    check_cnt(0);
    xfer(0, 32'h40, 1'b0, 32'h0, 4'hF);

    // Four wait states: abort by dropping cyc mid-WAIT, then reset mid-WAIT.
    xfer(2, 32'h30, 1'b1, 32'h5A5A5A5A, 4'hF);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 32'h30; we[2] = 1'b1;
    dat_i[2] = 32'h11111111; sel[2] = 4'hF;
    @(negedge clk);
    stb[2] = 1'b0;
    @(negedge clk);
    cyc[2] = 1'b0;
    repeat (10) @(negedge clk);
    check_cnt(2);
    xfer(2, 32'h30, 1'b0, 32'h0, 4'hF);

    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 32'h30; we[2] = 1'b1;
    dat_i[2] = 32'h12345678; sel[2] = 4'hF;
    @(negedge clk);
    stb[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1; cyc[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0; rd_exp[2] = 0; wr_exp[2] = 0;
    check_idle_outputs(2);
    repeat (8) @(negedge clk);
    xfer(2, 32'h30, 1'b0, 32'h0, 4'hF);
    check_cnt(2);

    // Read counter saturation.
    @(negedge clk);
    force dut_a.rd_cnt_o = 16'hFFFE;
    @(negedge clk);
    release dut_a.rd_cnt_o;
    rd_exp[0] = 16'hFFFE;
    @(negedge clk);
    check("rd_cnt_preset", 0, 64'(rd_cnt[0]), 64'h0FFFE);
    for (int i = 0; i < 3; i++) begin
      xfer(0, 32'h10, 1'b0, 32'h0, 4'hF);
      check_cnt(0);
    end

    // Window edges with a non-zero base address.
    xfer(1, 32'h0FFC, 1'b0, 32'h0, 4'hF);
    xfer(1, 32'h1000, 1'b0, 32'h0, 4'hF);
    xfer(1, 32'h17FC, 1'b1, 32'h600DCAFE, 4'hF);
    xfer(1, 32'h17FF, 1'b0, 32'h0, 4'hF);
    xfer(1, 32'h1800, 1'b0, 32'h0, 4'hF);
    check_cnt(1);

    // Randomized traffic over a preloaded window plus stray addresses.
    for (int d = 0; d < N; d++)
      for (int i = 0; i < 8; i++) xfer(d, base_of(d) + 32'(i * 4), 1'b1, $urandom, 4'hF);
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          if (d == 1 && $urandom_range(0, 1) == 1) a = base_of(d) - 32'($urandom_range(1, 64));
          else a = base_of(d) + 32'h800 + ($urandom & 32'hFFFF);
        end else begin
          a = base_of(d) + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        end
        xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      end
      check_cnt(d);
    end

    repeat (5) @(negedge clk);
    for (int d = 0; d < N; d++) check("scoreboard_drained", d, 64'(sb[d].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
